sayeh_mem_if: RTL and testbench
===============================

Name: sayeh_mem_if

Overview:
- Memory-bus interface directly downstream of the SAYEH controller.
- Converts the controller's level ReadMem/WriteMem strobes into a req/ack transaction on the external memory port.
- Inserts programmable wait states and returns read data with a one-cycle memDataReady pulse.
- Posts writes so the controller never stalls on sta. Adds a timeout so a dead memory cannot hang the CPU.

Parameters:
- WAIT_STATES, 0, idle cycles inserted between transaction launch and mem_req assertion (0..15).
- TIMEOUT_CYCLES, 64, maximum cycles mem_req may stay high without mem_ack before abort (≥2).
- ERR_DATA, 16'hFFFF, value returned on DataBusOut for a timed-out read.

Ports:
- clk  in  1  system clock, rising edge.
- ExternalReset  in  1  synchronous active-high reset.
- ReadMem  in  1  read request level from controller.
- WriteMem  in  1  write request from controller (single-cycle pulse).
- Address  in  16  address from address unit.
- DataBusIn  in  16  write data from operand bus.
- DataBusOut  out  16  registered read data to IR/register file.
- memDataReady  out  1  one-cycle pulse: DataBusOut valid.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  16  latched transaction address.
- mem_wdata  out  16  latched write data.
- mem_rdata  in  16  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single cycle.
- bus_err  out  1  sticky error flag.

Behaviour:
- Reset values: every output 0 except DataBusOut = 16'h0000. State = IDLE, pending_rd = 0, counters = 0. Reset mid-transaction aborts immediately with mem_req = 0 the next cycle; no memDataReady is issued.
- States:
  - IDLE
  - RD_WAIT
  - RD_REQ
  - RD_DONE
  - WR_WAIT
  - WR_REQ
- IDLE:
  - WriteMem=1 latches Address→mem_addr and DataBusIn→mem_wdata, sets mem_we=1, then goes to WR_WAIT (WAIT_STATES>0) or WR_REQ.
  - Else ReadMem=1 latches Address, sets mem_we=0, then goes to RD_WAIT or RD_REQ.
  - WriteMem has priority. If both are high in the same cycle, the write launches, pending_rd is set, and bus_err is set (illegal combination).
- RD_WAIT/WR_WAIT: wait counter counts WAIT_STATES cycles, then moves to the matching _REQ state.
- _REQ states:
  - mem_req=1 for the whole state.
  - Timeout counter clears on entry and increments each cycle.
  - mem_ack sampled high: mem_req<=0 at that same edge.
    - Read: DataBusOut<=mem_rdata, go to RD_DONE.
    - Write: go to IDLE.
  - Counter reaching TIMEOUT_CYCLES-1 with no ack: mem_req<=0, bus_err<=1.
    - Read: DataBusOut<=ERR_DATA, go to RD_DONE.
    - Write: go to IDLE (write dropped).
  - mem_ack arriving in the same cycle as the timeout: ack wins, no error.
- RD_DONE: memDataReady=1 for exactly this cycle, then IDLE. ReadMem seen in RD_DONE is ignored.
- Reads arriving while busy with a write: ReadMem high in any WR_* state sets pending_rd. When the write completes, the read launches directly, using Address sampled at launch. pending_rd clears on launch.
- Latency: read launched at edge E0 with WAIT_STATES=0 and mem_ack in the first req cycle gives mem_req high E0→E1, memDataReady high E1→E2.
- mem_ack outside a _REQ state is ignored.
- WriteMem arriving in any non-IDLE state is dropped and sets bus_err (one outstanding write only).
- bus_err clears only on ExternalReset.
- Wait and timeout counters are sized to hold WAIT_STATES and TIMEOUT_CYCLES and saturate, never wrap.

Test Plan:
- Reset: hold ExternalReset 3 cycles during an active read → mem_req=0 and memDataReady=0 after the first reset edge; DataBusOut=16'h0000, bus_err=0.
- Read, WAIT_STATES=0: ReadMem held, Address=16'h0040, memory acks the first req cycle with 16'hA5C3 → mem_req high exactly 1 cycle with mem_we=0, mem_addr=16'h0040; memDataReady pulses 1 cycle; DataBusOut=16'hA5C3.
- Wait states and slow memory: WAIT_STATES=3, ack on the 4th req cycle → mem_req rises 3 cycles after launch and stays high 4 cycles; memDataReady follows ack by 1 cycle.
- Posted write then read: WriteMem pulse (addr 16'h0100, data 16'h1234) with memory acking after 5 cycles; ReadMem asserted 2 cycles later at addr 16'h0002 → write completes first (mem_we=1, mem_wdata=16'h1234). The read launches in the cycle after the write ack; no error.
- Timeout: TIMEOUT_CYCLES=8, no ack → mem_req high exactly 8 cycles; DataBusOut=16'hFFFF; memDataReady pulses once; bus_err=1 and stays 1 until reset.
- Illegal overlap: ReadMem and WriteMem high together in IDLE → write executes first, then the read; bus_err=1.

Source files
------------

// File: rtl/sayeh_mem_if.sv
// SAYEH memory-bus interface: turns the controller's ReadMem/WriteMem strobes into a
// req/ack memory transaction with programmable wait states, posted writes and a timeout.
module sayeh_mem_if #(
  parameter int          WAIT_STATES    = 0,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] ERR_DATA       = 16'hFFFF
) (
  input  logic        clk,
  input  logic        ExternalReset,
  input  logic        ReadMem,
  input  logic        WriteMem,
  input  logic [15:0] Address,
  input  logic [15:0] DataBusIn,
  output logic [15:0] DataBusOut,
  output logic        memDataReady,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam int WW = 4;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_STATES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = {WW{1'b1}};
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = {TW{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_REQ  = 3'd2,
    RD_DONE = 3'd3,
    WR_WAIT = 3'd4,
    WR_REQ  = 3'd5
  } state_t;

  localparam state_t RD_FIRST = (WAIT_STATES > 0) ? RD_WAIT : RD_REQ;
  localparam state_t WR_FIRST = (WAIT_STATES > 0) ? WR_WAIT : WR_REQ;

  state_t        state, stateNxt;
  logic [WW-1:0] waitCnt, waitCntNxt;
  logic [TW-1:0] toCnt, toCntNxt;
  logic          pendingRd, pendingRdNxt;
  logic [15:0]   addrNxt, wdataNxt, doutNxt;
  logic          weNxt, errNxt;
  logic          errSet, pendSet, pendClr, wrBusy;

  // Next-state and next-output decode.
  always_comb begin
    stateNxt   = state;
    waitCntNxt = waitCnt;
    toCntNxt   = toCnt;
    addrNxt    = mem_addr;
    wdataNxt   = mem_wdata;
    weNxt      = mem_we;
    doutNxt    = DataBusOut;
    errSet     = 1'b0;
    pendSet    = 1'b0;
    pendClr    = 1'b0;
    wrBusy     = (state == WR_WAIT) || (state == WR_REQ);
    case (state)
      IDLE: begin
        waitCntNxt = {WW{1'b0}};
        toCntNxt   = {TW{1'b0}};
        if (WriteMem) begin
          addrNxt  = Address;
          wdataNxt = DataBusIn;
          weNxt    = 1'b1;
          stateNxt = WR_FIRST;
          pendSet  = ReadMem;
          errSet   = ReadMem;
        end else if (ReadMem || pendingRd) begin
          addrNxt  = Address;
          weNxt    = 1'b0;
          stateNxt = RD_FIRST;
          pendClr  = 1'b1;
        end else begin
          stateNxt = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (waitCnt == WAIT_LAST) begin
          stateNxt = (state == RD_WAIT) ? RD_REQ : WR_REQ;
          toCntNxt = {TW{1'b0}};
        end else begin
          waitCntNxt = (waitCnt == WAIT_MAX) ? waitCnt : waitCnt + {{(WW-1){1'b0}}, 1'b1};
        end
      end
      RD_REQ, WR_REQ: begin
        // An ack in the final timeout cycle still completes normally.
        if (mem_ack) begin
          if (state == RD_REQ) begin
            doutNxt  = mem_rdata;
            stateNxt = RD_DONE;
          end else begin
            stateNxt = IDLE;
          end
        end else if (toCnt == TO_LAST) begin
          errSet = 1'b1;
          if (state == RD_REQ) begin
            doutNxt  = ERR_DATA;
            stateNxt = RD_DONE;
          end else begin
            stateNxt = IDLE;
          end
        end else begin
          toCntNxt = (toCnt == TO_MAX) ? toCnt : toCnt + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      RD_DONE: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
    pendingRdNxt = (pendingRd & ~pendClr) | pendSet | (wrBusy & ReadMem);
    errNxt       = bus_err | errSet | ((state != IDLE) & WriteMem);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      state        <= IDLE;
      waitCnt      <= {WW{1'b0}};
      toCnt        <= {TW{1'b0}};
      pendingRd    <= 1'b0;
      DataBusOut   <= 16'h0000;
      memDataReady <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 16'h0000;
      mem_wdata    <= 16'h0000;
      bus_err      <= 1'b0;
    end else begin
      state        <= stateNxt;
      waitCnt      <= waitCntNxt;
      toCnt        <= toCntNxt;
      pendingRd    <= pendingRdNxt;
      DataBusOut   <= doutNxt;
      memDataReady <= (stateNxt == RD_DONE);
      mem_req      <= (stateNxt == RD_REQ) || (stateNxt == WR_REQ);
      mem_we       <= weNxt;
      mem_addr     <= addrNxt;
      mem_wdata    <= wdataNxt;
      bus_err      <= errNxt;
    end
  end

endmodule

// File: tb/tb_sayeh_mem_if.sv
// Bench for sayeh_mem_if: two instances (0 and 3 wait states) share controller inputs;
// a transaction-level model predicts every output each cycle, plus literal spot checks.
module tb_sayeh_mem_if;
  localparam int NDUT = 2;
  localparam int WS0 = 0;
  localparam int WS1 = 3;
  localparam int TO = 8;
  localparam logic [15:0] ERRV = 16'hFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ExternalReset, ReadMem, WriteMem;
  logic [15:0] Address, DataBusIn;
  logic [15:0] dout[NDUT], maddr[NDUT], wdata[NDUT], rdata[NDUT];
  logic rdy[NDUT], req[NDUT], we[NDUT], ack[NDUT], err[NDUT];

  sayeh_mem_if #(.WAIT_STATES(WS0), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .ExternalReset(ExternalReset), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .Address(Address), .DataBusIn(DataBusIn), .DataBusOut(dout[0]), .memDataReady(rdy[0]),
    .mem_req(req[0]), .mem_we(we[0]), .mem_addr(maddr[0]), .mem_wdata(wdata[0]),
    .mem_rdata(rdata[0]), .mem_ack(ack[0]), .bus_err(err[0]));

  sayeh_mem_if #(.WAIT_STATES(WS1), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .ExternalReset(ExternalReset), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .Address(Address), .DataBusIn(DataBusIn), .DataBusOut(dout[1]), .memDataReady(rdy[1]),
    .mem_req(req[1]), .mem_we(we[1]), .mem_addr(maddr[1]), .mem_wdata(wdata[1]),
    .mem_rdata(rdata[1]), .mem_ack(ack[1]), .bus_err(err[1]));

  // Transaction-level model: one outstanding transaction with a wait countdown and a req age.
  bit          mBusy[NDUT], mWe[NDUT], mDone[NDUT], mPend[NDUT], mErr[NDUT];
  logic [15:0] mAddr[NDUT], mWdata[NDUT], mDout[NDUT];
  int          mWait[NDUT], mAge[NDUT];

  int          reqCyc[NDUT], ackDelay[NDUT];
  logic [15:0] rdVal[NDUT];
  bit          randomMode;
  int          nChecks, nErrs;
  logic [31:0] cReq0, cRdy0, cReq1, cRdy1;

  function automatic int wsOf(input int i);
    return (i == 0) ? WS0 : WS1;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrs++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < NDUT; i++) begin
      if (ExternalReset) begin
        mBusy[i] = 0; mWe[i] = 0; mDone[i] = 0; mPend[i] = 0; mErr[i] = 0;
        mAddr[i] = 16'h0000; mWdata[i] = 16'h0000; mDout[i] = 16'h0000;
        mWait[i] = 0; mAge[i] = 0;
      end else if (mDone[i]) begin
        mDone[i] = 0;
        if (WriteMem) mErr[i] = 1;
      end else if (!mBusy[i]) begin
        if (WriteMem) begin
          mBusy[i] = 1; mWe[i] = 1; mAddr[i] = Address; mWdata[i] = DataBusIn;
          mWait[i] = wsOf(i); mAge[i] = 0;
          if (ReadMem) begin mPend[i] = 1; mErr[i] = 1; end
        end else if (ReadMem || mPend[i]) begin
          mBusy[i] = 1; mWe[i] = 0; mAddr[i] = Address;
          mWait[i] = wsOf(i); mAge[i] = 0; mPend[i] = 0;
        end
      end else begin
        if (WriteMem) mErr[i] = 1;
        if (mWe[i] && ReadMem) mPend[i] = 1;
        if (mWait[i] > 0) begin
          mWait[i]--;
        end else begin
          mAge[i]++;
          if (ack[i]) begin
            mBusy[i] = 0;
            if (!mWe[i]) begin mDout[i] = rdata[i]; mDone[i] = 1; end
          end else if (mAge[i] == TO) begin
            mBusy[i] = 0; mErr[i] = 1;
            if (!mWe[i]) begin mDout[i] = ERRV; mDone[i] = 1; end
          end
        end
      end
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < NDUT; i++) begin
      bit eReq;
      eReq = mBusy[i] && (mWait[i] == 0);
      chk("mem_req", i, req[i], eReq);
      chk("memDataReady", i, rdy[i], mDone[i]);
      chk("bus_err", i, err[i], mErr[i]);
      chk("DataBusOut", i, dout[i], mDout[i]);
      if (eReq) begin
        chk("mem_we", i, we[i], mWe[i]);
        chk("mem_addr", i, maddr[i], mAddr[i]);
        if (mWe[i]) chk("mem_wdata", i, wdata[i], mWdata[i]);
      end
    end
  endtask

  // Memory responder: acks on the ackDelay-th request cycle (0 = never).
  task automatic respond();
    for (int i = 0; i < NDUT; i++) begin
      rdata[i] = 16'($urandom);
      if (req[i]) begin
        reqCyc[i]++;
        if (randomMode && reqCyc[i] == 1)
          ackDelay[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
        ack[i] = (ackDelay[i] != 0) && (reqCyc[i] == ackDelay[i]);
        if (ack[i] && !randomMode) rdata[i] = rdVal[i];
      end else begin
        reqCyc[i] = 0;
        ack[i] = randomMode && ($urandom_range(0, 5) == 0);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    modelStep();
    compareAll();
    respond();
  endtask

  task automatic clearCap();
    cReq0 = 32'h0; cRdy0 = 32'h0; cReq1 = 32'h0; cRdy1 = 32'h0;
  endtask

  task automatic capture(input int n);
    cReq0[n-1] = req[0]; cRdy0[n-1] = rdy[0]; cReq1[n-1] = req[1]; cRdy1[n-1] = rdy[1];
  endtask

  initial begin
    nChecks = 0; nErrs = 0; randomMode = 0;
    ExternalReset = 1'b1; ReadMem = 1'b0; WriteMem = 1'b0;
    Address = 16'h0000; DataBusIn = 16'h0000;
    for (int i = 0; i < NDUT; i++) begin
      ack[i] = 1'b0; rdata[i] = 16'h0000; reqCyc[i] = 0; ackDelay[i] = 0; rdVal[i] = 16'h0000;
    end
    repeat (3) cyc();
    for (int i = 0; i < NDUT; i++) begin
      chk("reset DataBusOut", i, dout[i], 16'h0000);
      chk("reset mem_req", i, req[i], 1'b0);
      chk("reset bus_err", i, err[i], 1'b0);
    end

    // Reset asserted in the middle of a read.
    ExternalReset = 1'b0; ReadMem = 1'b1; Address = 16'h0040;
    cyc();
    chk("pre-reset mem_req", 0, req[0], 1'b1);
    cyc();
    ExternalReset = 1'b1; ReadMem = 1'b0;
    cyc();
    for (int i = 0; i < NDUT; i++) begin
      chk("midreset mem_req", i, req[i], 1'b0);
      chk("midreset memDataReady", i, rdy[i], 1'b0);
    end
    repeat (2) cyc();
    ExternalReset = 1'b0;
    cyc();
    for (int i = 0; i < NDUT; i++) begin
      chk("postreset DataBusOut", i, dout[i], 16'h0000);
      chk("postreset bus_err", i, err[i], 1'b0);
    end

    // Single read: instance 0 acks first req cycle, instance 1 acks fourth.
    ackDelay[0] = 1; ackDelay[1] = 4; rdVal[0] = 16'hA5C3; rdVal[1] = 16'h5A3C;
    ReadMem = 1'b1; Address = 16'h0040; clearCap();
    for (int n = 1; n <= 10; n++) begin
      cyc(); capture(n);
      if (n == 1) begin
        chk("rd mem_we", 0, we[0], 1'b0);
        chk("rd mem_addr", 0, maddr[0], 16'h0040);
      end
      if (n == 2) begin chk("rd data", 0, dout[0], 16'hA5C3); ReadMem = 1'b0; end
      if (n == 8) chk("rd data", 1, dout[1], 16'h5A3C);
    end
    chk("rd req window", 0, cReq0, 32'h00000001);
    chk("rd ready pulse", 0, cRdy0, 32'h00000002);
    chk("rd req window", 1, cReq1, 32'h00000078);
    chk("rd ready pulse", 1, cRdy1, 32'h00000080);

    // Posted write followed by a read issued while the write is outstanding.
    ackDelay[0] = 5; ackDelay[1] = 5; rdVal[0] = 16'h7E01; rdVal[1] = 16'h7E02;
    WriteMem = 1'b1; Address = 16'h0100; DataBusIn = 16'h1234; clearCap();
    for (int n = 1; n <= 20; n++) begin
      cyc(); capture(n);
      if (n == 1) WriteMem = 1'b0;
      if (n == 2) begin ReadMem = 1'b1; Address = 16'h0002; end
      if (n == 3) begin
        chk("wr mem_we", 0, we[0], 1'b1);
        chk("wr mem_wdata", 0, wdata[0], 16'h1234);
        chk("wr mem_addr", 0, maddr[0], 16'h0100);
      end
      if (n == 4) chk("wr mem_wdata", 1, wdata[1], 16'h1234);
      if (n == 7) begin
        chk("wr->rd mem_we", 0, we[0], 1'b0);
        chk("wr->rd mem_addr", 0, maddr[0], 16'h0002);
        ReadMem = 1'b0;
      end
      if (n == 12) chk("wr->rd data", 0, dout[0], 16'h7E01);
      if (n == 13) chk("wr->rd mem_addr", 1, maddr[1], 16'h0002);
      if (n == 18) chk("wr->rd data", 1, dout[1], 16'h7E02);
    end
    chk("wr->rd req window", 0, cReq0, 32'h000007DF);
    chk("wr->rd ready", 0, cRdy0, 32'h00000800);
    chk("wr->rd req window", 1, cReq1, 32'h0001F0F8);
    chk("wr->rd ready", 1, cRdy1, 32'h00020000);
    for (int i = 0; i < NDUT; i++) chk("wr->rd bus_err", i, err[i], 1'b0);

    // Read timeout against a dead memory.
    ackDelay[0] = 0; ackDelay[1] = 0;
    ReadMem = 1'b1; Address = 16'h0300; clearCap();
    for (int n = 1; n <= 14; n++) begin
      cyc(); capture(n);
      if (n == 1) ReadMem = 1'b0;
      if (n == 8) chk("to bus_err early", 0, err[0], 1'b0);
      if (n == 9) begin
        chk("to data", 0, dout[0], 16'hFFFF);
        chk("to bus_err", 0, err[0], 1'b1);
      end
      if (n == 12) chk("to data", 1, dout[1], 16'hFFFF);
    end
    chk("to req window", 0, cReq0, 32'h000000FF);
    chk("to ready", 0, cRdy0, 32'h00000100);
    chk("to req window", 1, cReq1, 32'h000007F8);
    chk("to ready", 1, cRdy1, 32'h00000800);
    repeat (5) cyc();
    for (int i = 0; i < NDUT; i++) chk("to bus_err sticky", i, err[i], 1'b1);
    ExternalReset = 1'b1;
    cyc();
    ExternalReset = 1'b0;
    for (int i = 0; i < NDUT; i++) chk("bus_err after reset", i, err[i], 1'b0);
    cyc();

    // ReadMem and WriteMem together: write first, then the read at the launch-time address.
    ackDelay[0] = 2; ackDelay[1] = 2; rdVal[0] = 16'hC0DE; rdVal[1] = 16'hD00D;
    ReadMem = 1'b1; WriteMem = 1'b1; Address = 16'h0200; DataBusIn = 16'hBEEF; clearCap();
    for (int n = 1; n <= 14; n++) begin
      cyc(); capture(n);
      if (n == 1) begin
        for (int i = 0; i < NDUT; i++) begin
          chk("ovl bus_err", i, err[i], 1'b1);
          chk("ovl mem_we", i, we[i], 1'b1);
        end
        chk("ovl mem_wdata", 0, wdata[0], 16'hBEEF);
        WriteMem = 1'b0; ReadMem = 1'b0; Address = 16'h0204;
      end
      if (n == 4) begin
        chk("ovl rd mem_we", 0, we[0], 1'b0);
        chk("ovl rd mem_addr", 0, maddr[0], 16'h0204);
      end
      if (n == 6) chk("ovl rd data", 0, dout[0], 16'hC0DE);
      if (n == 12) chk("ovl rd data", 1, dout[1], 16'hD00D);
    end
    chk("ovl req window", 0, cReq0, 32'h0000001B);
    chk("ovl ready", 0, cRdy0, 32'h00000020);
    chk("ovl req window", 1, cReq1, 32'h00000618);
    chk("ovl ready", 1, cRdy1, 32'h00000800);

    // Randomized traffic against the model.
    ExternalReset = 1'b1;
    repeat (2) cyc();
    ExternalReset = 1'b0;
    randomMode = 1;
    for (int k = 0; k < 4000; k++) begin
      WriteMem = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) ReadMem = ~ReadMem;
      Address = 16'($urandom);
      DataBusIn = 16'($urandom);
      ExternalReset = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
    $finish;
  end
endmodule
